// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Purpose  : MIPS E stage - control decode, operand forwarding, ALU and the
//            E/M pipeline register (IRM, PC4M, AOM, RTM).
// Options  : `E_SLT_EN enables slt/sltu decode and the ALU compare ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC4E,
  input  logic [31:0] IRE,
  input  logic [31:0] RSE,
  input  logic [31:0] RTE,
  input  logic [31:0] EXTE,
  input  logic [1:0]  Forward_RS_E_src,
  input  logic [1:0]  Forward_RT_E_src,
  input  logic [4:0]  Shift,
  input  logic [31:0] PC4_forw_M,
  input  logic [31:0] AO,
  input  logic [31:0] W_RF_WD_OUT,
  output logic [31:0] IRM,
  output logic [31:0] PC4M,
  output logic [31:0] AOM,
  output logic [31:0] RTM
);

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_OR   = 4'd2;
  localparam logic [3:0] c_ALU_AND  = 4'd3;
  localparam logic [3:0] c_ALU_LUI  = 4'd4;
  localparam logic [3:0] c_ALU_SLL  = 4'd5;
  localparam logic [3:0] c_ALU_SLT  = 4'd6;
  localparam logic [3:0] c_ALU_SLTU = 4'd7;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [5:0] c_FN_SLL   = 6'b000000;
  localparam logic [5:0] c_FN_JR    = 6'b001000;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
`ifdef E_SLT_EN
  localparam logic [5:0] c_FN_SLT   = 6'b101010;
  localparam logic [5:0] c_FN_SLTU  = 6'b101011;
`endif

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [3:0]  w_alu_op;
  logic        w_alu_src;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_res;

  assign w_opcode = IRE[31:26];
  assign w_funct  = IRE[5:0];

  // Unlisted encodings (including j/jal) fall back to ADD on registers.
  always_comb begin
    w_alu_op  = c_ALU_ADD;
    w_alu_src = 1'b0;
    case (w_opcode)
      c_OP_RTYPE: begin
        case (w_funct)
          c_FN_ADDU: w_alu_op = c_ALU_ADD;
          c_FN_SUBU: w_alu_op = c_ALU_SUB;
          c_FN_AND:  w_alu_op = c_ALU_AND;
          c_FN_OR:   w_alu_op = c_ALU_OR;
          c_FN_SLL:  w_alu_op = c_ALU_SLL;
          c_FN_JR:   w_alu_op = c_ALU_ADD;
`ifdef E_SLT_EN
          c_FN_SLT:  w_alu_op = c_ALU_SLT;
          c_FN_SLTU: w_alu_op = c_ALU_SLTU;
`endif
          default:   w_alu_op = c_ALU_ADD;
        endcase
      end
      c_OP_ORI: begin
        w_alu_op  = c_ALU_OR;
        w_alu_src = 1'b1;
      end
      c_OP_LUI: begin
        w_alu_op  = c_ALU_LUI;
        w_alu_src = 1'b1;
      end
      c_OP_ADDIU, c_OP_LW, c_OP_SW: begin
        w_alu_op  = c_ALU_ADD;
        w_alu_src = 1'b1;
      end
      c_OP_BEQ: begin
        w_alu_op  = c_ALU_SUB;
        w_alu_src = 1'b0;
      end
      default: begin
        w_alu_op  = c_ALU_ADD;
        w_alu_src = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (Forward_RS_E_src)
      2'd0:    w_fwd_rs = RSE;
      2'd1:    w_fwd_rs = AO;
      2'd2:    w_fwd_rs = PC4_forw_M;
      default: w_fwd_rs = W_RF_WD_OUT;
    endcase
  end

  always_comb begin
    case (Forward_RT_E_src)
      2'd0:    w_fwd_rt = RTE;
      2'd1:    w_fwd_rt = AO;
      2'd2:    w_fwd_rt = PC4_forw_M;
      default: w_fwd_rt = W_RF_WD_OUT;
    endcase
  end

  assign w_src_a = w_fwd_rs;
  assign w_src_b = w_alu_src ? EXTE : w_fwd_rt;

  always_comb begin
    case (w_alu_op)
      c_ALU_ADD:  w_alu_res = w_src_a + w_src_b;
      c_ALU_SUB:  w_alu_res = w_src_a - w_src_b;
      c_ALU_OR:   w_alu_res = w_src_a | w_src_b;
      c_ALU_AND:  w_alu_res = w_src_a & w_src_b;
      c_ALU_LUI:  w_alu_res = {w_src_b[15:0], 16'h0000};
      c_ALU_SLL:  w_alu_res = w_src_b << Shift;
`ifdef E_SLT_EN
      c_ALU_SLT:  w_alu_res = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
      c_ALU_SLTU: w_alu_res = {31'd0, (w_src_a < w_src_b)};
`endif
      default:    w_alu_res = 32'd0;
    endcase
  end

  // RTM takes the forwarded rt, not SrcB, so store data is never the offset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IRM  <= 32'd0;
      PC4M <= 32'd0;
      AOM  <= 32'd0;
      RTM  <= 32'd0;
    end else begin
      IRM  <= IRE;
      PC4M <= PC4E;
      AOM  <= w_alu_res;
      RTM  <= w_fwd_rt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

  logic        Clk;
  logic        Reset;
  logic [31:0] PC4E, IRE, RSE, RTE, EXTE;
  logic [1:0]  Forward_RS_E_src, Forward_RT_E_src;
  logic [4:0]  Shift;
  logic [31:0] PC4_forw_M, AO, W_RF_WD_OUT;
  logic [31:0] IRM, PC4M, AOM, RTM;

  int n_tests = 0;
  int n_fail  = 0;

  execute_stage dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .PC4E             (PC4E),
    .IRE              (IRE),
    .RSE              (RSE),
    .RTE              (RTE),
    .EXTE             (EXTE),
    .Forward_RS_E_src (Forward_RS_E_src),
    .Forward_RT_E_src (Forward_RT_E_src),
    .Shift            (Shift),
    .PC4_forw_M       (PC4_forw_M),
    .AO               (AO),
    .W_RF_WD_OUT      (W_RF_WD_OUT),
    .IRM              (IRM),
    .PC4M             (PC4M),
    .AOM              (AOM),
    .RTM              (RTM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ext, input logic [1:0] frs, input logic [1:0] frt,
                       input logic [4:0] sh);
    IRE = ir; RSE = rs; RTE = rt; EXTE = ext;
    Forward_RS_E_src = frs; Forward_RT_E_src = frt; Shift = sh;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    PC4E = 32'h0000_3004; PC4_forw_M = 32'h0000_3008;
    AO = 32'h0000_0100; W_RF_WD_OUT = 32'h0000_DEAD;
    drive(32'h0022_1821, 32'h7FFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 5'd0);
    #2;
    chk("reset_irm",  IRM,  32'h0);
    chk("reset_pc4m", PC4M, 32'h0);
    chk("reset_aom",  AOM,  32'h0);
    chk("reset_rtm",  RTM,  32'h0);
    tick();
    chk("reset_held_aom", AOM, 32'h0);
    Reset = 1'b0;

    // addu overflow wraps
    tick();
    chk("addu_aom",  AOM,  32'h8000_0000);
    chk("addu_rtm",  RTM,  32'h0000_0001);
    chk("addu_irm",  IRM,  32'h0022_1821);
    chk("addu_pc4m", PC4M, 32'h0000_3004);

    // async reset mid-cycle with non-zero outputs
    #2 Reset = 1'b1;
    #1;
    chk("async_irm",  IRM,  32'h0);
    chk("async_pc4m", PC4M, 32'h0);
    chk("async_aom",  AOM,  32'h0);
    chk("async_rtm",  RTM,  32'h0);
    tick();
    chk("async_held_irm", IRM, 32'h0);
    chk("async_held_aom", AOM, 32'h0);
    #2 Reset = 1'b0;

    // first edge after release loads (same addu still on inputs)
    tick();
    chk("release_aom", AOM, 32'h8000_0000);

    drive(32'h3422_ABCD, 32'h1234_0000, 32'h5555_5555, 32'h0000_ABCD, 2'd0, 2'd0, 5'd0);
    tick();
    chk("ori_aom", AOM, 32'h1234_ABCD);
    chk("ori_rtm", RTM, 32'h5555_5555);

    drive(32'h3C02_BEEF, 32'hFFFF_FFFF, 32'h0, 32'h0000_BEEF, 2'd0, 2'd0, 5'd0);
    tick();
    chk("lui_aom", AOM, 32'hBEEF_0000);

    // sw with forwarded base and forwarded store data
    drive(32'hAC22_0008, 32'h0, 32'h0, 32'h0000_0008, 2'd1, 2'd3, 5'd0);
    tick();
    chk("sw_fwd_aom", AOM, 32'h0000_0108);
    chk("sw_fwd_rtm", RTM, 32'h0000_DEAD);

    drive(32'h0022_1821, 32'h0, 32'h0, 32'h0, 2'd2, 2'd2, 5'd0);
    tick();
    chk("fwd2_aom", AOM, 32'h0000_6010);
    chk("fwd2_rtm", RTM, 32'h0000_3008);

    drive(32'h0002_17C0, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 5'd31);
    tick();
    chk("sll_aom", AOM, 32'h8000_0000);

    drive(32'h0022_1823, 32'h0, 32'h1, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
    chk("subu_aom", AOM, 32'hFFFF_FFFF);

    drive(32'h0022_1824, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
    chk("and_aom", AOM, 32'h00F0_F000);

    drive(32'h0022_1825, 32'hF000_0000, 32'h0000_000F, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
    chk("or_aom", AOM, 32'hF000_000F);

    // beq uses rt even though EXTE is non-zero
    drive(32'h1022_0003, 32'h5, 32'h3, 32'h64, 2'd0, 2'd0, 5'd0);
    tick();
    chk("beq_aom", AOM, 32'h0000_0002);

    drive(32'h2422_FFFC, 32'h10, 32'h7, 32'hFFFF_FFFC, 2'd0, 2'd0, 5'd0);
    tick();
    chk("addiu_aom", AOM, 32'h0000_000C);

    drive(32'h8C22_0010, 32'h1000, 32'h7, 32'h10, 2'd3, 2'd0, 5'd0);
    tick();
    chk("lw_fwd3_aom", AOM, 32'h0000_DEBD);

    drive(32'h0C00_0010, 32'h2, 32'h3, 32'h40, 2'd0, 2'd0, 5'd0);
    tick();
    chk("jal_aom", AOM, 32'h0000_0005);

    drive(32'h0020_0008, 32'h0000_4000, 32'h0, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
    chk("jr_aom", AOM, 32'h0000_4000);

    // slt / sltu: A=0xFFFFFFFF, B=1
    drive(32'h0022_182A, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
`ifdef E_SLT_EN
    chk("slt_aom", AOM, 32'h0000_0001);
`else
    chk("slt_default_add", AOM, 32'h0000_0000);
`endif
    drive(32'h0022_182B, 32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
    chk("sltu_aom", AOM, 32'h0000_0000);

    // bubble
    drive(32'h0, 32'h1234, 32'h0, 32'h0, 2'd0, 2'd0, 5'd0);
    tick();
    chk("nop_irm", IRM, 32'h0);
    chk("nop_aom", AOM, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Execute (E) stage of the five-stage MIPS pipeline: decodes the instruction held in the D/E register, selects forwarded operands for rs and rt, performs the ALU operation, and latches the E/M pipeline register (IRM, PC4M, AOM, RTM). It sits between the D/E register and the memory stage. It contains three combinational sub-functions (control decode, E-stage forwarding mux, ALU) plus one register bank.

## Interface
Parameters: none.
Clock is `Clk`; reset is `Reset`, asynchronous and active-high.
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous active-high reset of the E/M register
- PC4E  in  32  PC+4 of the E-stage instruction
- IRE  in  32  instruction word in E
- RSE  in  32  rs value read in D
- RTE  in  32  rt value read in D
- EXTE  in  32  extended immediate from D
- Forward_RS_E_src  in  2  rs operand select
- Forward_RT_E_src  in  2  rt operand select
- Shift  in  5  shift amount (shamt)
- PC4_forw_M  in  32  link value forwarded from M
- AO  in  32  ALU result held in M (AOM of the older instruction)
- W_RF_WD_OUT  in  32  register-file write data in W
- IRM  out  32  registered IRE
- PC4M  out  32  registered PC4E
- AOM  out  32  registered ALU result
- RTM  out  32  registered forwarded rt (store data)

## Operation
- Forwarding, independently for rs and rt:
  - select 0: RSE/RTE
  - select 1: AO
  - select 2: PC4_forw_M
  - select 3: W_RF_WD_OUT
- SrcA = forwarded rs.
- SrcB = EXTE when ALUsrc=1, else forwarded rt.
- Decode (opcode IRE[31:26], funct IRE[5:0]) to 4-bit ALUop and ALUsrc.
- ALUop encoding:
  - 0 ADD (A+B, wrap mod 2^32, no overflow trap)
  - 1 SUB (A−B, wrap)
  - 2 OR
  - 3 AND
  - 4 LUI (B<<16)
  - 5 SLL (B<<Shift)
  - 6 SLT (signed A<B ? 1 : 0)
  - 7 SLTU (unsigned)
  - 8–15 produce 0
- R-type (opcode 000000), ALUsrc=0:
  - addu 100001 → ADD
  - subu 100011 → SUB
  - and 100100 → AND
  - or 100101 → OR
  - sll 000000 → SLL
  - jr 001000 → ADD
  - slt 101010 → SLT (only with macro)
  - sltu 101011 → SLTU (only with macro)
- I-type, ALUsrc=1:
  - ori 001101 → OR
  - lui 001111 → LUI
  - addiu 001001 → ADD
  - lw 100011 → ADD
  - sw 101011 → ADD
- beq 000100 → SUB, ALUsrc=0.
- j/jal and any unlisted encoding → ADD, ALUsrc=0.
- Zero/sign extension of immediates is done upstream; the ALU uses EXTE as given.
- RTM always captures the forwarded rt (not SrcB), so stores get the correct data.

## Timing
- Decode, forwarding mux and ALU are purely combinational, within one cycle.
- E/M register: on each rising Clk edge with Reset low:
  - IRM←IRE
  - PC4M←PC4E
  - AOM←ALU result
  - RTM←forwarded rt
- Latency is exactly 1 cycle from E inputs to outputs.
- Reset asserted at any time forces all four outputs to 0 immediately, independent of Clk. A zero IRM acts as a nop (sll $0,$0,0).
- Reset held high across a clock edge keeps the outputs at 0.
- The first edge after Reset deasserts loads normally.
- No stall or enable input: the register loads every cycle. Bubbles are inserted upstream by feeding IRE=0.
- Forward selects and data may change any time before setup; there is no handshake.

## Configuration
- Macro `E_SLT_EN`.
  - Defined: slt/sltu funct codes decode to ALUop 6/7 with the comparisons above.
  - Undefined: these functs fall into the default case (ADD, ALUsrc=0), and ALUop 6/7 produce 0.
- All other behaviour is identical in both builds.

## Test plan
- Assert Reset mid-cycle with the outputs non-zero → IRM/PC4M/AOM/RTM read 0 before the next edge and stay 0 while Reset is high.
- addu with RSE=0x7FFFFFFF, RTE=1, selects 0/0 → after one edge AOM=0x80000000, RTM=1, IRM=IRE, PC4M=PC4E.
- ori with RSE=0x12340000, EXTE=0x0000ABCD → AOM=0x1234ABCD. lui with EXTE=0x0000BEEF → AOM=0xBEEF0000.
- Forwarding: sw with Forward_RS_E_src=1 (AO=0x100), EXTE=8, Forward_RT_E_src=3 (W_RF_WD_OUT=0xDEAD) → AOM=0x108, RTM=0xDEAD. Select 2 with PC4_forw_M=0x3008 → operand equals 0x3008.
- sll with RTE=1, Shift=31 → AOM=0x80000000. subu 0−1 → 0xFFFFFFFF.
- With `E_SLT_EN`: slt with A=0xFFFFFFFF, B=1 → AOM=1; sltu with the same operands → 0. Without the macro, slt yields A+B=0x00000000.
